// File: rtl/instr_encoder_loader.sv
// Packs mnemonic + register/immediate fields into MIPS32 words and streams them
// into instruction memory through a small write FIFO during program preload.
module instr_encoder_loader #(
    parameter int AW         = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WORDS  = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [5:0]    in_mnem,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_shamt,
    input  logic [25:0]   in_imm,
    input  logic          im_gnt,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [31:0]   im_wdata,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   word_cnt,
    output logic          err_illegal,
    output logic [1:0]    fsm_state
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int ACW = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;
    typedef enum logic [1:0] {K_R, K_I, K_J} kind_t;

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on registered state, never on in_valid.

    state_t          state, state_nxt;
    logic [31:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [ACW-1:0]  acc_cnt;
    logic [AW-1:0]   wr_addr;
    logic            fifo_full, fifo_nonempty;
    logic            accept, push, pop, legal;
    kind_t           kind;
    logic [5:0]      op, funct;
    logic            is_shift, is_jr, is_jalr, is_lui;
    logic [4:0]      f_rs, f_rt, f_rd, f_sh;
    logic [31:0]     enc_word;

    always_comb begin
        op    = 6'h00;
        funct = 6'h00;
        kind  = K_R;
        legal = 1'b1;
        case (in_mnem)
            6'd0:  funct = 6'h20;
            6'd1:  funct = 6'h21;
            6'd2:  funct = 6'h22;
            6'd3:  funct = 6'h23;
            6'd4:  funct = 6'h24;
            6'd5:  funct = 6'h25;
            6'd6:  funct = 6'h26;
            6'd7:  funct = 6'h27;
            6'd8:  funct = 6'h2a;
            6'd9:  funct = 6'h2b;
            6'd10: funct = 6'h00;
            6'd11: funct = 6'h02;
            6'd12: funct = 6'h03;
            6'd13: funct = 6'h04;
            6'd14: funct = 6'h06;
            6'd15: funct = 6'h07;
            6'd16: funct = 6'h08;
            6'd17: funct = 6'h09;
            6'd18: begin kind = K_I; op = 6'h08; end
            6'd19: begin kind = K_I; op = 6'h0c; end
            6'd20: begin kind = K_I; op = 6'h0d; end
            6'd21: begin kind = K_I; op = 6'h0a; end
            6'd22: begin kind = K_I; op = 6'h0f; end
            6'd23: begin kind = K_I; op = 6'h23; end
            6'd24: begin kind = K_I; op = 6'h20; end
            6'd25: begin kind = K_I; op = 6'h21; end
            6'd26: begin kind = K_I; op = 6'h24; end
            6'd27: begin kind = K_I; op = 6'h25; end
            6'd28: begin kind = K_I; op = 6'h2b; end
            6'd29: begin kind = K_I; op = 6'h28; end
            6'd30: begin kind = K_I; op = 6'h29; end
            6'd31: begin kind = K_I; op = 6'h04; end
            6'd32: begin kind = K_I; op = 6'h05; end
            6'd33: begin kind = K_J; op = 6'h02; end
            6'd34: begin kind = K_J; op = 6'h03; end
            default: legal = 1'b0;
        endcase
    end

    // Unused fields are zeroed so the encoded word is canonical.
    assign is_shift = (in_mnem == 6'd10) || (in_mnem == 6'd11) || (in_mnem == 6'd12);
    assign is_jr    = (in_mnem == 6'd16);
    assign is_jalr  = (in_mnem == 6'd17);
    assign is_lui   = (in_mnem == 6'd22);
    assign f_rs     = (is_shift || is_lui) ? 5'd0 : in_rs;
    assign f_rt     = (is_jr || is_jalr) ? 5'd0 : in_rt;
    assign f_rd     = is_jr ? 5'd0 : in_rd;
    assign f_sh     = is_shift ? in_shamt : 5'd0;

    always_comb begin
        enc_word = '0;
        case (kind)
            K_R:     enc_word = {6'h00, f_rs, f_rt, f_rd, f_sh, funct};
            K_I:     enc_word = {op, f_rs, f_rt, in_imm[15:0]};
            K_J:     enc_word = {op, in_imm};
            default: enc_word = '0;
        endcase
    end

    assign fifo_full     = (count == CW'(FIFO_DEPTH));
    assign fifo_nonempty = (count != '0);
    assign in_ready      = (state == S_LOAD) && !fifo_full && (acc_cnt < ACW'(MAX_WORDS));
    assign accept        = in_valid && in_ready;
    assign push          = accept && legal;
    // Gated by rst so a reset cycle can never leak a write from a discarded FIFO.
    assign im_we         = fifo_nonempty && im_gnt && !rst;
    assign pop           = im_we;
    assign im_addr       = wr_addr;
    assign im_wdata      = fifo_nonempty ? mem[rd_ptr] : 32'h0;
    assign busy          = (state != S_IDLE);
    assign fsm_state     = state;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  if (accept && in_last) state_nxt = S_DRAIN;
            S_DRAIN: if (!fifo_nonempty) state_nxt = S_DONE;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            acc_cnt     <= '0;
            wr_addr     <= '0;
            word_cnt    <= '0;
            err_illegal <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                wr_addr     <= start_addr;
                word_cnt    <= '0;
                err_illegal <= 1'b0;
                acc_cnt     <= '0;
            end else begin
                if (pop) begin
                    wr_addr  <= wr_addr + AW'(1);
                    word_cnt <= word_cnt + (AW+1)'(1);
                end
                if (accept) acc_cnt <= acc_cnt + ACW'(1);
                if (accept && !legal) err_illegal <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: table vectors, hand-written corner sequences
// and randomized sessions checked against an arithmetic encoding model.
module tb_instr_encoder_loader;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_last, im_gnt;
    logic [AW-1:0] start_addr;
    logic [5:0]    in_mnem;
    logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
    logic [25:0]   in_imm;
    logic          in_ready, im_we, busy, done, err_illegal;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic [AW:0]   word_cnt;
    logic [1:0]    fsm_state;

    instr_encoder_loader #(.AW(AW), .FIFO_DEPTH(4), .MAX_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .im_gnt(im_gnt), .im_we(im_we),
        .im_addr(im_addr), .im_wdata(im_wdata), .busy(busy), .done(done),
        .word_cnt(word_cnt), .err_illegal(err_illegal), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  mnem;
        logic [4:0]  rs, rt, rd, shamt;
        logic [25:0] imm;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[12];

    int            n_vec = 0;
    int            n_mis = 0;
    logic [41:0]   exp_q[$];
    logic [41:0]   mon_e;
    logic [AW-1:0] exp_addr;
    int            exp_words;
    logic          exp_err;
    logic          gnt_fixed = 1'b0;
    logic          gnt_rand  = 1'b0;

    int r_funct[18] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 4, 6, 7, 8, 9};
    int i_op[15]    = '{8, 12, 13, 10, 15, 35, 32, 33, 36, 37, 43, 40, 41, 4, 5};

    function automatic logic [31:0] model_enc(int m, int rs, int rt, int rd, int sh, int imm);
        longint w;
        if (m < 18) begin
            if (m >= 10 && m <= 12) rs = 0;
            else sh = 0;
            if (m == 16) begin rt = 0; rd = 0; end
            if (m == 17) rt = 0;
            w = longint'(rs) * 2**21 + rt * 2**16 + rd * 2**11 + sh * 64 + r_funct[m];
        end else if (m < 33) begin
            if (m == 22) rs = 0;
            w = longint'(i_op[m-18]) * 2**26 + longint'(rs) * 2**21 + rt * 2**16 + (imm % 65536);
        end else begin
            w = longint'(m - 31) * 2**26 + (imm % 2**26);
        end
        return w[31:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every IM write must match the oldest expected {addr, word}.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            if (exp_q.size() == 0) check("spurious_write", 64'(im_we), 64'd0);
            else begin
                mon_e = exp_q.pop_front();
                check("im_addr", 64'(im_addr), 64'(mon_e[41:32]));
                check("im_wdata", 64'(im_wdata), 64'(mon_e[31:0]));
            end
        end
    end

    initial begin
        im_gnt = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            im_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_fixed;
        end
    end

    initial begin
        #500000;
        n_mis++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic start_session(input logic [AW-1:0] addr);
        start_addr = addr;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_addr = addr;
        exp_words = 0;
        exp_err = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_word_cnt", 64'(word_cnt), 64'd0);
        check("start_err_clear", 64'(err_illegal), 64'd0);
    endtask

    task automatic drive_fields(input int m, input int rs, input int rt, input int rd,
                                input int sh, input int imm, input bit last);
        in_mnem = 6'(m); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_shamt = 5'(sh); in_imm = 26'(imm); in_last = last;
    endtask

    task automatic model_accept(input int m, input logic [31:0] expw);
        if (m < 35) begin
            exp_q.push_back({exp_addr, expw});
            exp_addr = exp_addr + 1'b1;
            exp_words++;
        end else exp_err = 1'b1;
    endtask

    task automatic send_beat(input int m, input int rs, input int rt, input int rd, input int sh,
                             input int imm, input bit last, input logic [31:0] expw);
        bit acc = 1'b0;
        bit rdy;
        drive_fields(m, rs, rt, rd, sh, imm, last);
        in_valid = 1'b1;
        for (int c = 0; c < 300 && !acc; c++) begin
            @(negedge clk);
            rdy = in_ready;
            tick();
            if (rdy) acc = 1'b1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!acc) check("beat_accept_timeout", 64'(acc), 64'd1);
        else model_accept(m, expw);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            check("done_word_cnt", 64'(word_cnt), 64'(exp_words));
            check("done_err_illegal", 64'(err_illegal), 64'(exp_err));
            check("done_busy", 64'(busy), 64'd1);
            check("all_written", 64'(exp_q.size()), 64'd0);
            @(negedge clk);
            check("done_one_cycle", 64'(done), 64'd0);
            check("idle_not_busy", 64'(busy), 64'd0);
        end
        tick();
    endtask

    task automatic rand_beat(input bit last, input bit legal_only);
        int m, rs, rt, rd, sh, imm;
        if (legal_only || $urandom_range(0, 9) < 8) m = $urandom_range(0, 34);
        else m = $urandom_range(35, 63);
        rs = $urandom_range(0, 31); rt = $urandom_range(0, 31); rd = $urandom_range(0, 31);
        sh = $urandom_range(0, 31); imm = $urandom_range(0, 2**26 - 1);
        send_beat(m, rs, rt, rd, sh, imm, last, (m < 35) ? model_enc(m, rs, rt, rd, sh, imm) : 32'h0);
    endtask

    initial begin
        int bp_m[6] = '{1, 3, 5, 19, 24, 29};
        int idx;
        bit rdy;

        vecs[0]  = '{6'd0,  5'd1,  5'd2,  5'd3,  5'd0,  26'h0,       32'h00221820};
        vecs[1]  = '{6'd10, 5'd7,  5'd1,  5'd2,  5'd4,  26'h0,       32'h00011100};
        vecs[2]  = '{6'd7,  5'd1,  5'd2,  5'd3,  5'd5,  26'h0,       32'h00221827};
        vecs[3]  = '{6'd12, 5'd9,  5'd10, 5'd11, 5'd31, 26'h0,       32'h000A5FC3};
        vecs[4]  = '{6'd15, 5'd3,  5'd4,  5'd5,  5'd7,  26'h0,       32'h00642807};
        vecs[5]  = '{6'd16, 5'd31, 5'd5,  5'd6,  5'd3,  26'h0,       32'h03E00008};
        vecs[6]  = '{6'd17, 5'd4,  5'd3,  5'd31, 5'd2,  26'h0,       32'h0080F809};
        vecs[7]  = '{6'd22, 5'd5,  5'd1,  5'd0,  5'd0,  26'h1234,    32'h3C011234};
        vecs[8]  = '{6'd28, 5'd29, 5'd31, 5'd7,  5'd0,  26'hFFFC,    32'hAFBFFFFC};
        vecs[9]  = '{6'd31, 5'd1,  5'd2,  5'd0,  5'd0,  26'h2AFFFF,  32'h1022FFFF};
        vecs[10] = '{6'd20, 5'd2,  5'd3,  5'd0,  5'd0,  26'hABCD,    32'h3443ABCD};
        vecs[11] = '{6'd34, 5'd0,  5'd0,  5'd0,  5'd0,  26'h3FFFFFF, 32'h0FFFFFFF};

        rst = 1'b1; start = 1'b0; start_addr = '0; in_valid = 1'b0;
        drive_fields(0, 0, 0, 0, 0, 0, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_im_we", 64'(im_we), 64'd0);
        check("rst_im_addr", 64'(im_addr), 64'd0);
        check("rst_im_wdata", 64'(im_wdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_word_cnt", 64'(word_cnt), 64'd0);
        check("rst_err_illegal", 64'(err_illegal), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single add, write appears in the cycle after acceptance.
        gnt_fixed = 1'b1;
        start_session(10'd0);
        send_beat(0, 1, 2, 3, 0, 0, 1'b1, 32'h00221820);
        @(negedge clk);
        check("first_write_latency", 64'(im_we), 64'd1);
        tick();
        wait_done();

        // addi / lw / j program at addresses 0..2.
        start_session(10'd0);
        send_beat(18, 0, 8, 0, 0, 5, 1'b0, 32'h20080005);
        send_beat(23, 29, 9, 0, 0, 4, 1'b0, 32'h8FA90004);
        send_beat(33, 0, 0, 0, 0, 26'h100000, 1'b1, 32'h08100000);
        wait_done();

        // Table of hand-encoded vectors in one session.
        start_session(10'd100);
        for (int i = 0; i < 12; i++)
            send_beat(vecs[i].mnem, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].shamt,
                      vecs[i].imm, i == 11, vecs[i].exp);
        wait_done();

        // Grant withheld: FIFO fills after 4 accepts, nothing written.
        gnt_fixed = 1'b0;
        start_session(10'd200);
        idx = 0;
        drive_fields(bp_m[0], 1, 2, 3, 0, 16'h100, 1'b0);
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_no_write", 64'(im_we), 64'd0);
            rdy = in_ready && in_valid;
            tick();
            if (rdy) begin
                model_accept(bp_m[idx], model_enc(bp_m[idx], idx + 1, idx + 2, idx + 3, idx, idx * 4 + 16'h100));
                idx++;
                drive_fields(bp_m[idx], idx + 1, idx + 2, idx + 3, idx, idx * 4 + 16'h100, 1'b0);
            end
        end
        in_valid = 1'b0;
        check("bp_accepts", 64'(idx), 64'd4);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_word_cnt", 64'(word_cnt), 64'd0);
        gnt_fixed = 1'b1;
        for (int k = 4; k < 6; k++)
            send_beat(bp_m[k], k + 1, k + 2, k + 3, k, k * 4 + 16'h100, k == 5,
                      model_enc(bp_m[k], k + 1, k + 2, k + 3, k, k * 4 + 16'h100));
        wait_done();

        // Address wrap from the top of IM.
        start_session(10'd1023);
        send_beat(0, 4, 5, 6, 0, 0, 1'b0, model_enc(0, 4, 5, 6, 0, 0));
        send_beat(2, 7, 8, 9, 0, 0, 1'b1, model_enc(2, 7, 8, 9, 0, 0));
        wait_done();

        // Illegal mnemonic mid-stream is dropped and flagged until next start.
        start_session(10'd10);
        send_beat(0, 1, 2, 3, 0, 0, 1'b0, 32'h00221820);
        send_beat(40, 1, 2, 3, 0, 0, 1'b0, 32'h0);
        check("err_set", 64'(err_illegal), 64'd1);
        send_beat(5, 1, 2, 3, 0, 0, 1'b1, model_enc(5, 1, 2, 3, 0, 0));
        wait_done();
        repeat (2) tick();
        check("err_sticky_idle", 64'(err_illegal), 64'd1);
        start_session(10'd20);
        send_beat(19, 3, 4, 0, 0, 16'h00FF, 1'b1, model_enc(19, 3, 4, 0, 0, 16'h00FF));
        wait_done();

        // Reset during LOAD with three words queued.
        gnt_fixed = 1'b0;
        start_session(10'd30);
        for (int k = 0; k < 3; k++) rand_beat(1'b0, 1'b1);
        check("queued_no_write", 64'(word_cnt), 64'd0);
        do_reset();
        gnt_fixed = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("post_rst_no_write", 64'(im_we), 64'd0);
        end
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_word_cnt", 64'(word_cnt), 64'd0);
        tick();

        // MAX_WORDS beats without in_last: intake stops, session stays open.
        start_session(10'd5);
        for (int k = 0; k < 1024; k++) rand_beat(1'b0, 1'b1);
        repeat (6) @(negedge clk);
        check("max_in_ready_low", 64'(in_ready), 64'd0);
        check("max_busy", 64'(busy), 64'd1);
        check("max_word_cnt", 64'(word_cnt), 64'd1024);
        check("max_all_written", 64'(exp_q.size()), 64'd0);
        tick();
        do_reset();
        tick();

        // Randomized sessions with random grant and idle gaps.
        gnt_rand = 1'b1;
        for (int s = 0; s < 8; s++) begin
            int n;
            n = $urandom_range(3, 20);
            start_session(AW'($urandom_range(0, 1023)));
            for (int k = 0; k < n; k++) begin
                rand_beat(k == n - 1, 1'b0);
                repeat ($urandom_range(0, 2)) tick();
            end
            wait_done();
        end
        gnt_rand = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
